// File: rtl/load_store_unit.sv
// RV32I load/store front-end for MagicMemory; SB/SH via read-modify-write, bad accesses flagged without touching memory.
// Latency: error 1 cycle, LW/LB/LH/SW 2 cycles, SB/SH 3 cycles. Backpressure: req_ready only in IDLE, response never stalls.
module load_store_unit #(
    parameter int               ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_we,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE_W, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_write_data_q, mem_write_data_d;
    logic              mem_we_q, mem_we_d;

    logic        req_illegal, req_misaligned, req_range, req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    always_comb begin
        req_illegal    = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                                : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));
        req_misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                       | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        req_range      = (req_addr >= ADDR_LIMIT);
        req_err        = req_illegal | req_misaligned | req_range;
    end

    // Lane selection and sign/zero extension of the fetched word.
    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = mem_read_data[7:0];
            2'd1:    ld_byte = mem_read_data[15:8];
            2'd2:    ld_byte = mem_read_data[23:16];
            default: ld_byte = mem_read_data[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_read_data;
        endcase
        merged = mem_read_data;
        if (funct3_q[0]) merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
        else             merged[{addr_lo_q, 3'b000} +: 8]     = wdata_q[7:0];
    end

    always_comb begin
        state_d          = state_q;
        addr_lo_d        = addr_lo_q;
        funct3_d         = funct3_q;
        wdata_d          = wdata_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        req_ready_d      = 1'b0;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = 32'h0;
        resp_err_d       = 1'b0;
        mem_we_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_lo_d = req_addr[1:0];
                    funct3_d  = req_funct3;
                    wdata_d   = req_wdata[15:0];
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (!req_we) begin
                            state_d = S_LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            state_d          = S_STORE_W;
                            mem_we_d         = 1'b1;
                            mem_write_data_d = req_wdata;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_ext;
            end
            S_RMW_RD: begin
                state_d          = S_RMW_WR;
                mem_we_d         = 1'b1;
                mem_write_data_d = merged;
            end
            S_STORE_W, S_RMW_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            addr_lo_q        <= 2'b00;
            funct3_q         <= 3'b000;
            wdata_q          <= 16'h0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'h0;
            resp_err_q       <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= 32'h0;
            mem_we_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_lo_q        <= addr_lo_d;
            funct3_q         <= funct3_d;
            wdata_q          <= wdata_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_we_q         <= mem_we_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_we         = mem_we_q;

endmodule
